// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int unsigned FLG_N = 0;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_V = 3;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StExec = 1'b1;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit (LSB first) per clock.
// done_o marks the edge that performs the final iteration; prod_o is the product at that edge.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int unsigned CNTW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = CNTW'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNTW'(1);
    end
  end

  assign done_o = (cnt_q == CNTW'(1));
  assign prod_o = acc_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with issue/complete handshake; single-cycle ops complete at the accept edge,
// shifts and multiply iterate in EXEC and complete at edge k+N.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [2:0]       OP,
  input  logic             FLGON,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  output logic [WIDTH-1:0] ALUREG,
  output logic [3:0]       FLG,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned CNTW = $clog2(WIDTH) + 1;

  logic [0:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             flgon_q, flgon_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] alureg_q, alureg_d;
  logic [3:0]       flg_q, flg_d;
  logic             done_q, done_d;

  logic               accept;
  logic [CNTW-1:0]    n_iss;
  logic [WIDTH:0]     add_full;
  logic [WIDTH-1:0]   sub_res;
  logic [WIDTH-1:0]   one_res;
  logic               one_c, one_v;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic               last;
  logic               wr_en, wr_flg, wr_c, wr_v;
  logic [WIDTH-1:0]   wr_res;

  assign accept   = EN && (state_q == StIdle);
  assign add_full = {1'b0, D1} + {1'b0, D2};
  assign sub_res  = D1 - D2;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .start_i (accept && (OP == OP_MUL)),
    .a_i     (D1),
    .b_i     (D2),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  always_comb begin
    n_iss = '0;
    if (OP == OP_SHL || OP == OP_SHR) n_iss = {1'b0, D2[CNTW-2:0]};
    else if (OP == OP_MUL)            n_iss = CNTW'(WIDTH);
  end

  // Zero-iteration result; a shift by 0 passes D1 through with C=0.
  always_comb begin
    one_res = D1;
    one_c   = 1'b0;
    one_v   = 1'b0;
    case (OP)
      OP_ADD: begin
        one_res = add_full[WIDTH-1:0];
        one_c   = add_full[WIDTH];
        one_v   = (D1[WIDTH-1] == D2[WIDTH-1]) && (add_full[WIDTH-1] != D1[WIDTH-1]);
      end
      OP_SUB: begin
        one_res = sub_res;
        one_c   = (D1 < D2);
        one_v   = (D1[WIDTH-1] != D2[WIDTH-1]) && (sub_res[WIDTH-1] != D1[WIDTH-1]);
      end
      OP_AND:  one_res = D1 & D2;
      OP_OR:   one_res = D1 | D2;
      OP_NOT:  one_res = ~D1;
      default: one_res = D1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    flgon_d = flgon_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_flg  = 1'b0;
    wr_res  = one_res;
    wr_c    = 1'b0;
    wr_v    = 1'b0;
    last    = 1'b0;
    if (state_q == StIdle) begin
      if (accept) begin
        op_d    = OP;
        flgon_d = FLGON;
        sh_d    = D1;
        cnt_d   = n_iss;
        if (n_iss == '0) begin
          wr_en  = 1'b1;
          wr_flg = FLGON;
          wr_res = one_res;
          wr_c   = one_c;
          wr_v   = one_v;
          done_d = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
    end else begin
      last = (op_q == OP_MUL) ? mul_done : (cnt_q == CNTW'(1));
      if (op_q == OP_SHL) begin
        sh_d = sh_q << 1;
        wr_c = sh_q[WIDTH-1];
      end else begin
        sh_d = sh_q >> 1;
        wr_c = sh_q[0];
      end
      wr_res = sh_d;
      if (op_q == OP_MUL) begin
        wr_res = mul_prod[WIDTH-1:0];
        wr_c   = |mul_prod[2*WIDTH-1:WIDTH];
        wr_v   = wr_c;
      end
      cnt_d = cnt_q - CNTW'(1);
      if (last) begin
        wr_en   = 1'b1;
        wr_flg  = flgon_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    alureg_d = alureg_q;
    flg_d    = flg_q;
    if (wr_en) alureg_d = wr_res;
    if (wr_en && wr_flg) begin
      flg_d[FLG_N] = wr_res[WIDTH-1];
      flg_d[FLG_Z] = (wr_res == '0);
      flg_d[FLG_C] = wr_c;
      flg_d[FLG_V] = wr_v;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      op_q     <= '0;
      flgon_q  <= 1'b0;
      sh_q     <= '0;
      cnt_q    <= '0;
      alureg_q <= '0;
      flg_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      flgon_q  <= flgon_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      alureg_q <= alureg_d;
      flg_q    <= flg_d;
      done_q   <= done_d;
    end
  end

  assign ALUREG = alureg_q;
  assign FLG    = flg_q;
  assign BUSY   = (state_q == StExec);
  assign DONE   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench: the driver queues hand-computed results with their expected DONE cycle;
// a negedge monitor pops and compares on every DONE pulse.
module tb_alu_seq;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        EN;
  logic [2:0]  OP;
  logic        FLGON;
  logic [15:0] D1, D2;
  logic [15:0] ALUREG;
  logic [3:0]  FLG;
  logic        BUSY, DONE;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  alu_seq #(
    .WIDTH (16)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .EN     (EN),
    .OP     (OP),
    .FLGON  (FLGON),
    .D1     (D1),
    .D2     (D2),
    .ALUREG (ALUREG),
    .FLG    (FLG),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge with EN still high.
  task automatic issue(input logic [2:0] op, input logic [15:0] d1, input logic [15:0] d2,
                       input logic fl, input int n, input logic [15:0] er, input logic [3:0] ef,
                       input bit push);
    exp_t e;
    EN = 1'b1; OP = op; D1 = d1; D2 = d2; FLGON = fl;
    if (push) begin
      e.res = er; e.flg = ef; e.cyc = cyc + 1 + n;
      sb.push_back(e);
    end
    @(negedge CLK);
  endtask

  task automatic idle();
    EN = 1'b0; OP = 3'b000; D1 = 16'h0; D2 = 16'h0; FLGON = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (BUSY && i < 100) begin
      @(negedge CLK);
      i++;
    end
    check("busy_timeout", {31'b0, BUSY}, 32'd0);
  endtask

  always @(negedge CLK) begin
    if (RST_N && DONE) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("alureg", {16'b0, ALUREG}, {16'b0, e.res});
        check("flg", {28'b0, FLG}, {28'b0, e.flg});
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N = 1'b0;
    idle();
    repeat (2) @(negedge CLK);
    check("rst_alureg", {16'b0, ALUREG}, 32'd0);
    check("rst_flg", {28'b0, FLG}, 32'd0);
    check("rst_busy", {31'b0, BUSY}, 32'd0);
    check("rst_done", {31'b0, DONE}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // ADD signed overflow, SUB zero, SUB with flags gated off
    issue(3'b000, 16'h7FFF, 16'h0001, 1'b1, 0, 16'h8000, 4'b1001, 1'b1); idle(); @(negedge CLK);
    issue(3'b001, 16'd7, 16'd7, 1'b1, 0, 16'h0000, 4'b0010, 1'b1); idle(); @(negedge CLK);
    issue(3'b001, 16'd5, 16'd10, 1'b0, 0, 16'hFFFB, 4'b0010, 1'b1); idle(); @(negedge CLK);

    // MUL with ignored EN pulses while busy
    issue(3'b111, 16'd300, 16'd300, 1'b1, 16, 16'h5F90, 4'b1100, 1'b1);
    idle();
    for (int i = 0; i < 16; i++) begin
      check("mul_busy", {31'b0, BUSY}, 32'd1);
      check("mul_hold", {16'b0, ALUREG}, 32'h0000FFFB);
      EN = (i == 3 || i == 7); OP = 3'b000; D1 = 16'd1; D2 = 16'd1; FLGON = 1'b1;
      @(negedge CLK);
    end
    idle();
    check("mul_busy_end", {31'b0, BUSY}, 32'd0);
    @(negedge CLK);

    // Shifts
    issue(3'b101, 16'h8001, 16'd1, 1'b1, 1, 16'h0002, 4'b0100, 1'b1); idle(); wait_idle();
    @(negedge CLK);
    issue(3'b110, 16'h00F0, 16'd20, 1'b1, 4, 16'h000F, 4'b0000, 1'b1); idle(); wait_idle();
    @(negedge CLK);
    issue(3'b101, 16'h1234, 16'd16, 1'b1, 0, 16'h1234, 4'b0000, 1'b1); idle(); @(negedge CLK);

    // Reset at the edge of MUL iteration 8 aborts it
    issue(3'b111, 16'd300, 16'd300, 1'b1, 16, 16'h0, 4'b0, 1'b0);
    idle();
    repeat (7) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    check("abort_alureg", {16'b0, ALUREG}, 32'd0);
    check("abort_flg", {28'b0, FLG}, 32'd0);
    check("abort_busy", {31'b0, BUSY}, 32'd0);
    check("abort_done", {31'b0, DONE}, 32'd0);
    RST_N = 1'b1;
    repeat (12) @(negedge CLK);
    issue(3'b000, 16'd10, 16'd5, 1'b1, 0, 16'h000F, 4'b0000, 1'b1); idle(); @(negedge CLK);

    // Back-to-back single-cycle ops
    issue(3'b010, 16'hCCCC, 16'hAAAA, 1'b1, 0, 16'h8888, 4'b0001, 1'b1);
    issue(3'b011, 16'hCCCC, 16'hAAAA, 1'b1, 0, 16'hEEEE, 4'b0001, 1'b1);
    issue(3'b100, 16'hAAAA, 16'h0000, 1'b1, 0, 16'h5555, 4'b0000, 1'b1);
    idle();
    repeat (3) @(negedge CLK);

    check("pending", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, clocked successor to the 16-bit combinational ALU.
- Operand width is generic, and ALUREG and the flags are registered.
- Adds iterative shift and multiply ops that take multiple cycles.
- Issue/complete handshake (EN, BUSY, DONE) so the CPU control FSM can stall on long ops.
- Extends the flag set from {Z,N} to {V,C,Z,N}; the FLGON gating semantics are unchanged.

Parameters:
WIDTH, 16, operand/result width in bits (>=4, power of two)
CNTW, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
CLK     in   1      rising-edge clock
RST_N   in   1      synchronous reset, active-low
EN      in   1      issue request; sampled on a CLK edge when BUSY=0
OP      in   3      operation code, sampled with EN
FLGON   in   1      flag update enable, sampled with EN
D1      in   WIDTH  operand 1, sampled with EN
D2      in   WIDTH  operand 2 / shift count, sampled with EN
ALUREG  out  WIDTH  registered result; holds until the next completion
FLG     out  4      [0]=N, [1]=Z, [2]=C, [3]=V; registered
BUSY    out  1      multi-cycle op in progress
DONE    out  1      one-cycle pulse: ALUREG/FLG updated at the preceding edge

Behaviour:
- Reset (RST_N=0 at an edge): ALUREG=0, FLG=0, BUSY=0, DONE=0, FSM=IDLE. A reset during an op aborts it: no DONE, no result write.
- Acceptance: at an edge with EN=1 and BUSY=0, OP, FLGON, D1 and D2 are latched. EN while BUSY=1 is ignored, with no queueing.
- OP encoding:
  - 000 ADD
  - 001 SUB (D1-D2)
  - 010 AND
  - 011 OR
  - 100 NOT D1
  - 101 SHL D1 by D2 mod WIDTH
  - 110 SHR logical D1 by D2 mod WIDTH
  - 111 MUL (low WIDTH bits of D1*D2, unsigned)
- Iteration count N:
  - ops 000-100: N=0
  - SHL/SHR: N = D2[CNTW-2:0], one bit per cycle
  - MUL: N=WIDTH, shift-add on the D2 LSB first
- FSM states: IDLE, EXEC.
  - IDLE, accept with N=0: result is written at the accept edge; DONE=1 for the next cycle; stay in IDLE.
  - IDLE, accept with N>0: go to EXEC; BUSY=1 from the next cycle.
  - EXEC: one iteration per edge. At the edge completing iteration N: write the result, BUSY->0, DONE=1 for one cycle, go to IDLE.
- Latency: DONE is high in the cycle after edge k+N, where k is the accept edge.
- Throughput:
  - N=0 ops can be issued every cycle; DONE stays high across back-to-back ops.
  - A new op may be accepted in the same cycle that DONE is high.
- Flags: updated at the result edge only if the latched FLGON=1; otherwise FLG holds its old value. ALUREG always updates.
  - Z = (result==0); N = result[WIDTH-1]
  - ADD: C = carry out; V = signed overflow
  - SUB: C = borrow (D1<D2 unsigned); V = signed overflow
  - AND/OR/NOT: C=0, V=0
  - SHL/SHR: C = last bit shifted out; 0 if N=0
  - MUL: C = V = (upper WIDTH bits of the 2*WIDTH product != 0)
- Arithmetic wraps modulo 2^WIDTH. Latched operands are immune to input changes after acceptance.

Decomposition:
- Package alu_pkg holds:
  - the OP localparams (OP_ADD..OP_MUL)
  - the flag index constants (FLG_N=0, FLG_Z=1, FLG_C=2, FLG_V=3)
  - the FSM state encoding
- One sub-module, alu_mul_iter:
  - iterative shift-add multiplier, parameter WIDTH
  - start/done interface; returns the 2*WIDTH product
- Top-level alu_seq owns the FSM, shifter, single-cycle datapath and flag logic.

Test Plan:
1. ADD: D1=0x7FFF, D2=0x0001, FLGON=1 -> DONE in the cycle after the accept edge; ALUREG=0x8000; FLG=4'b1001.
2. SUB: D1=7, D2=7, FLGON=1 -> ALUREG=0, FLG=4'b0010. Then D1=5, D2=10, FLGON=0 -> ALUREG=0xFFFB, FLG still 4'b0010.
3. MUL: D1=300, D2=300, FLGON=1 -> BUSY high 16 cycles; DONE after edge k+16; ALUREG=0x5F90; FLG=4'b1100. EN pulses during BUSY are ignored and ALUREG is unchanged.
4. SHL: D1=0x8001, D2=1 -> ALUREG=0x0002, C=1. SHR: D1=0x00F0, D2=20 (count 4) -> ALUREG=0x000F, C=0, DONE after edge k+4. SHL with D2=16 -> N=0, ALUREG=D1, C=0.
5. Reset mid-MUL: RST_N=0 at iteration 8 -> ALUREG=0, FLG=0, BUSY=0, no DONE pulse; a fresh ADD 10+5 afterwards gives ALUREG=15.
6. Back-to-back: EN held high, issuing AND 0xCCCC&0xAAAA, then OR, then NOT 0xAAAA on successive cycles -> DONE high 3 cycles; ALUREG sequence 0x8888, 0xEEEE, 0x5555.
